// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: arbitrates fetch vs data access, runs the
// req/ack handshake, returns read data and drives pipeline load/stall controls.
module mem_port_sched #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          pc_load,
  output logic          ifid_load,
  output logic          stall,
  output logic          err
);

  // state | meaning
  // IDLE  | no transfer outstanding, arbitrating requesters
  // FETCH | instruction read in flight, m_req high
  // DATA  | load/store in flight, m_req high
  // ERR   | watchdog expired, memory presumed hung; exit only by reset
  typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       last_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
      last_data <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          // on contention, whoever was not served last goes next
          if (d_req && (!if_req || !last_data)) begin
            state     <= DATA;
            m_req     <= 1'b1;
            m_we      <= d_we;
            m_addr    <= d_addr;
            m_wdata   <= d_wdata;
            last_data <= 1'b1;
          end else if (if_req) begin
            state     <= FETCH;
            m_req     <= 1'b1;
            m_we      <= 1'b0;
            m_addr    <= if_addr;
            last_data <= 1'b0;
          end
        end
        FETCH, DATA: begin
          if (m_ack) begin
            if (state == FETCH) begin
              if_rdata <= m_rdata;
              if_valid <= 1'b1;
            end else begin
              d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (wait_cnt == WAIT_LIM) begin
            state <= ERR;
            m_req <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_load   = if_valid & ~err;
  assign ifid_load = if_valid & ~err;
  assign stall     = (d_req & ~d_valid) | err;

endmodule

// File: tb/tb_mem_port_sched.sv
// Randomized bench for mem_port_sched: transaction-level model of grants,
// handshake latency, data return and watchdog against the DUT.
module tb_mem_port_sched;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, m_ack;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_wdata, m_rdata, if_rdata, d_rdata;
  logic          m_req, m_we, if_valid, d_valid, pc_load, ifid_load, stall, err;

  always #5 clk = ~clk;

  mem_port_sched #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .pc_load(pc_load), .ifid_load(ifid_load), .stall(stall), .err(err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // requester model and expected-result state
  logic        if_on, d_on, d_w, lg_data;
  logic [31:0] if_a, d_a, d_wd, exp_if_rd, exp_d_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    if_req  = if_on;
    if_addr = if_a;
    d_req   = d_on;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    if_on = 1'b0;
    d_on  = 1'b0;
    drive();
    m_ack = 1'b0;
    #13;
    rst       = 1'b1;
    lg_data   = 1'b0;
    exp_if_rd = '0;
    exp_d_rd  = '0;
    tick();
  endtask

  function automatic logic pick_data();
    return d_on && (!if_on || !lg_data);
  endfunction

  // Called with the DUT idle and requests already driven; ends in the valid cycle.
  task automatic xfer(input int d, input logic [31:0] rd);
    logic        kd;
    logic [31:0] ea;
    logic        ew;
    kd = pick_data();
    ea = kd ? d_a : if_a;
    ew = kd ? d_w : 1'b0;
    tick();
    for (int i = 0; i <= d; i++) begin
      chk("req_high", 32'(m_req), 1);
      chk("addr", m_addr, ea);
      chk("we", 32'(m_we), 32'(ew));
      if (kd) chk("wdata", m_wdata, d_wd);
      chk("stall_busy", 32'(stall), 32'(d_on));
      chk("valid_busy", 32'({if_valid, d_valid}), 0);
      chk("err_busy", 32'(err), 0);
      if (i == d) begin
        m_ack   = 1'b1;
        m_rdata = rd;
      end
      tick();
    end
    m_ack   = 1'b0;
    m_rdata = $urandom;
    if (kd) exp_d_rd = rd;
    else    exp_if_rd = rd;
    lg_data = kd;
    chk("req_done", 32'(m_req), 0);
    chk("we_done", 32'(m_we), 0);
    chk("if_valid", 32'(if_valid), 32'(!kd));
    chk("d_valid", 32'(d_valid), 32'(kd));
    chk("pc_load", 32'(pc_load), 32'(!kd));
    chk("ifid_load", 32'(ifid_load), 32'(!kd));
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("d_rdata", d_rdata, exp_d_rd);
    chk("stall_valid", 32'(stall), 32'(d_on && !kd));
    chk("err_done", 32'(err), 0);
  endtask

  initial begin
    rst = 1'b0; m_ack = 1'b0; m_rdata = '0;
    if_on = 0; d_on = 0; d_w = 0; if_a = '0; d_a = '0; d_wd = '0;
    lg_data = 0; exp_if_rd = '0; exp_d_rd = '0;
    drive();
    do_reset();
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_valids", 32'({if_valid, d_valid}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);

    // single fetch, immediate ack
    if_on = 1; if_a = 32'h100; drive();
    xfer(0, 32'h0050_0093);
    if_on = 0; drive();

    // store with 3 wait cycles
    d_on = 1; d_w = 1; d_a = 32'h2000; d_wd = 32'hDEAD_BEEF; drive();
    xfer(3, 32'h1234_5678);
    d_on = 0; drive();

    // contention after reset: DATA first, then alternate
    do_reset();
    if_on = 1; if_a = 32'h400; d_on = 1; d_w = 0; d_a = 32'h3000; d_wd = 32'h0; drive();
    for (int k = 0; k < 4; k++) begin
      chk("contend_grant", 32'(pick_data()), 32'(k % 2 == 0));
      xfer(0, $urandom);
    end

    // watchdog with ack never arriving
    do_reset();
    if_on = 1; if_a = 32'h500; drive();
    tick();
    chk("wd_req_rise", 32'(m_req), 1);
    for (int i = 1; i <= MAX_WAIT; i++) begin
      tick();
      chk("wd_req_hold", 32'(m_req), 1);
      chk("wd_no_err", 32'(err), 0);
    end
    tick();
    chk("wd_req_drop", 32'(m_req), 0);
    chk("wd_err", 32'(err), 1);
    m_ack = 1; d_on = 1; drive();
    tick();
    m_ack = 0;
    for (int i = 0; i < 4; i++) begin
      chk("err_req", 32'(m_req), 0);
      chk("err_valids", 32'({if_valid, d_valid}), 0);
      chk("err_sticky", 32'(err), 1);
      chk("err_stall", 32'(stall), 1);
      chk("err_pc_load", 32'(pc_load), 0);
      tick();
    end

    // ack on the limit cycle completes normally
    do_reset();
    if_on = 1; if_a = 32'h600; drive();
    xfer(MAX_WAIT, 32'hCAFE_0001);
    if_on = 0; drive();

    // async reset in the middle of a data access
    d_on = 1; d_w = 1; d_a = 32'h7000; d_wd = 32'h5555_AAAA; drive();
    tick(); tick(); tick();
    chk("mid_req", 32'(m_req), 1);
    #2;
    rst = 0; d_on = 0; drive();
    #1;
    chk("arst_req", 32'(m_req), 0);
    chk("arst_we", 32'(m_we), 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_wdata", m_wdata, 0);
    chk("arst_rdata", if_rdata | d_rdata, 0);
    chk("arst_misc", 32'({if_valid, d_valid, err, stall, pc_load}), 0);
    #3;
    rst = 1; lg_data = 0; exp_if_rd = '0; exp_d_rd = '0;
    tick();
    if_on = 1; if_a = 32'h800; drive();
    xfer(1, 32'h0BAD_F00D);
    if_on = 0; drive();

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      if (!if_on && !d_on) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("idle_req", 32'(m_req), 0);
          chk("idle_valids", 32'({if_valid, d_valid}), 0);
        end
        if_on = $urandom_range(0, 1);
        d_on  = !if_on || ($urandom_range(0, 1) == 1);
        if_a = $urandom; d_a = $urandom; d_wd = $urandom; d_w = $urandom_range(0, 1);
        drive();
      end
      xfer($urandom_range(0, MAX_WAIT), $urandom);
      if (lg_data) begin
        d_on = $urandom_range(0, 1);
        d_a = $urandom; d_wd = $urandom; d_w = $urandom_range(0, 1);
        if (!if_on && $urandom_range(0, 1) == 1) begin
          if_on = 1; if_a = $urandom;
        end
      end else begin
        if_on = $urandom_range(0, 1);
        if_a = $urandom;
        if (!d_on && $urandom_range(0, 1) == 1) begin
          d_on = 1; d_a = $urandom; d_wd = $urandom; d_w = $urandom_range(0, 1);
        end
      end
      drive();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
